// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with registered one-hot grant, hold-until-release and optional hold-limit preemption.
// Define RR_ARB_FIXED_PRIO_EN to replace the rotating pointer with fixed priority (bit N-1 highest).
module rr_onehot_arbiter #(
    parameter int N        = 3,
    parameter int MAX_HOLD = 8,
    parameter int IW       = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld,
    output logic          preempt
);

    localparam int              HW        = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam bit              HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [HW-1:0]   HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
    localparam logic [IW-1:0]   IDX_LAST  = IW'(N - 1);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t        r_state;
    logic [N-1:0]  r_gnt;
    logic [IW-1:0] r_gnt_idx;
    logic          r_gnt_vld;
    logic          r_preempt;
    logic [HW-1:0] r_hold_cnt;

    state_t        w_state_nxt;
    logic [N-1:0]  w_gnt_nxt;
    logic [IW-1:0] w_idx_nxt;
    logic          w_vld_nxt;
    logic          w_preempt_nxt;
    logic [HW-1:0] w_hold_nxt;
    logic [IW-1:0] w_win_idx;
    logic [N-1:0]  w_win_oh;
    logic          w_owner_req;
    logic          w_others_req;

`ifdef RR_ARB_FIXED_PRIO_EN
    // Highest set bit wins; the ascending loop lets later (higher) bits override.
    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) w_win_idx = IW'(i);
        end
    end
`else
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_ptr_nxt;
    logic          w_release;
    logic [N-1:0]  w_mask;
    logic [N-1:0]  w_pick;

    // Requests at or above ptr take precedence; otherwise wrap to the lowest set bit.
    always_comb begin
        w_mask    = '0;
        w_win_idx = '0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (i >= int'(r_ptr));
        end
        w_pick = ((req & w_mask) != '0) ? (req & w_mask) : req;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_pick[i]) w_win_idx = IW'(i);
        end
    end

    assign w_release = (r_state == S_GRANT) && (w_state_nxt == S_IDLE);
    assign w_ptr_nxt = (r_gnt_idx == IDX_LAST) ? '0 : r_gnt_idx + IW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_release) begin
            r_ptr <= w_ptr_nxt;
        end
    end
`endif

    assign w_win_oh     = N'(1) << w_win_idx;
    assign w_owner_req  = |(req & r_gnt);
    assign w_others_req = |(req & ~r_gnt);

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_idx_nxt     = r_gnt_idx;
        w_vld_nxt     = r_gnt_vld;
        w_preempt_nxt = 1'b0;
        w_hold_nxt    = r_hold_cnt;
        case (r_state)
            S_IDLE: begin
                w_gnt_nxt = '0;
                w_idx_nxt = '0;
                w_vld_nxt = 1'b0;
                if (req != '0) begin
                    w_state_nxt = S_GRANT;
                    w_gnt_nxt   = w_win_oh;
                    w_idx_nxt   = w_win_idx;
                    w_vld_nxt   = 1'b1;
                    w_hold_nxt  = '0;
                end
            end
            S_GRANT: begin
                // An owner drop outranks preemption, so a coinciding drop never pulses preempt.
                if (!w_owner_req) begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_vld_nxt   = 1'b0;
                end else if (HOLD_EN && (r_hold_cnt == HOLD_LAST) && w_others_req) begin
                    w_state_nxt   = S_IDLE;
                    w_gnt_nxt     = '0;
                    w_idx_nxt     = '0;
                    w_vld_nxt     = 1'b0;
                    w_preempt_nxt = 1'b1;
                end else if (HOLD_EN && (r_hold_cnt != HOLD_LAST)) begin
                    w_hold_nxt = r_hold_cnt + HW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
                w_idx_nxt   = '0;
                w_vld_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_gnt_idx  <= '0;
            r_gnt_vld  <= 1'b0;
            r_preempt  <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gnt_idx  <= w_idx_nxt;
            r_gnt_vld  <= w_vld_nxt;
            r_preempt  <= w_preempt_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign gnt_idx = r_gnt_idx;
    assign gnt_vld = r_gnt_vld;
    assign preempt = r_preempt;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Scoreboard bench for rr_onehot_arbiter: a cycle-level owner/pointer model queues expected outputs,
// a monitor pops and compares them every cycle.
module tb_rr_onehot_arbiter;

    localparam int N        = 3;
    localparam int MAX_HOLD = 4;
    localparam int IW       = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          gnt_vld;
    logic          preempt;

    typedef struct packed {
        logic [N-1:0]  gnt;
        logic [IW-1:0] idx;
        logic          vld;
        logic          pre;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;

    // Model state: current owner (-1 = none), search start, cycles the owner has held the grant.
    int   m_owner = -1;
    int   m_ptr   = 0;
    int   m_held  = 0;

    rr_onehot_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int want);
        n_total++;
        if (act == want) n_pass++;
        else $display("FAIL %s: actual %0d required %0d at t=%0t", name, act, want, $time);
    endtask

    function automatic bit req_bit(input logic [N-1:0] r, input int i);
        return ((int'(r) >> i) & 1) == 1;
    endfunction

    function automatic int pick(input logic [N-1:0] r);
`ifdef RR_ARB_FIXED_PRIO_EN
        for (int i = N - 1; i >= 0; i--) if (req_bit(r, i)) return i;
`else
        for (int k = 0; k < N; k++) if (req_bit(r, (m_ptr + k) % N)) return (m_ptr + k) % N;
`endif
        return -1;
    endfunction

    task automatic push_exp(input bit pre);
        exp_t e;
        e.gnt = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        e.idx = (m_owner >= 0) ? IW'(m_owner) : '0;
        e.vld = (m_owner >= 0);
        e.pre = pre;
        sb_q.push_back(e);
    endtask

    task automatic model_step(input logic [N-1:0] r);
        bit pre;
        pre = 1'b0;
        if (m_owner < 0) begin
            m_owner = pick(r);
            m_held  = 1;
        end else if (!req_bit(r, m_owner)) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else if (MAX_HOLD != 0 && m_held >= MAX_HOLD && (int'(r) & ~(1 << m_owner)) != 0) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            pre     = 1'b1;
        end else begin
            m_held++;
        end
        push_exp(pre);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        push_exp(1'b0);
    endtask

    // One clock of stimulus; reset assertion is checked for its immediate effect.
    task automatic step(input logic [N-1:0] r, input logic rn);
        @(negedge clk);
        req   = r;
        rst_n = rn;
        if (!rn) begin
            #1;
            check("async_rst_gnt", int'(gnt), 0);
            check("async_rst_vld", int'(gnt_vld), 0);
        end
        @(posedge clk);
        if (!rn) model_reset();
        else model_step(r);
    endtask

    always @(posedge clk) begin
        #2;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("gnt", int'(gnt), int'(mon_e.gnt));
            check("gnt_idx", int'(gnt_idx), int'(mon_e.idx));
            check("gnt_vld", int'(gnt_vld), int'(mon_e.vld));
            check("preempt", int'(preempt), int'(mon_e.pre));
            check("onehot0", int'($onehot0(gnt)), 1);
        end
    end

    initial begin
        logic [N-1:0] r;
        rst_n = 1'b0;
        req   = '1;

        // Reset with all requests pending, then release.
        step(3'b111, 1'b0);
        step(3'b111, 1'b0);
        step(3'b111, 1'b1);
        repeat (3) step(3'b000, 1'b1);

        // Single requester for five cycles.
        repeat (5) step(3'b001, 1'b1);
        repeat (3) step(3'b000, 1'b1);

        // Rotation: each owner drops its bit after two grant cycles.
        for (int c = 0; c < 20; c++) begin
            r = 3'b111;
            if (m_owner >= 0 && m_held >= 2) r = r & ~N'(1 << m_owner);
            step(r, 1'b1);
        end
        repeat (3) step(3'b000, 1'b1);

        // Preemption: requester 0 holds, requester 1 joins once 0 is granted.
        step(3'b001, 1'b1);
        repeat (10) step(3'b011, 1'b1);
        repeat (3) step(3'b000, 1'b1);

        // Wrap: grant to 1, release, then 0 and 2 compete.
        repeat (2) step(3'b010, 1'b1);
        step(3'b000, 1'b1);
        repeat (3) step(3'b101, 1'b1);
        step(3'b001, 1'b1);
        repeat (3) step(3'b101, 1'b1);
        repeat (2) step(3'b000, 1'b1);

        // Reset in the middle of a grant, then search restarts from 0.
        repeat (2) step(3'b010, 1'b1);
        step(3'b010, 1'b0);
        repeat (3) step(3'b110, 1'b1);
        repeat (2) step(3'b000, 1'b1);

        // Priority order from idle.
        step(3'b011, 1'b1); step(3'b000, 1'b1); step(3'b000, 1'b1);
        step(3'b110, 1'b1); step(3'b000, 1'b1); step(3'b000, 1'b1);
        step(3'b111, 1'b1); step(3'b000, 1'b1); step(3'b000, 1'b1);

        // Randomized traffic with sticky requests and rare resets.
        r = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, (1 << N) - 1));
            step(r, ($urandom_range(0, 199) != 0));
        end

        repeat (2) @(posedge clk);
        #5;
        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- Round-robin arbiter for N requesters. Produces a registered, strictly one-hot grant vector and a matching encoded index.
- Generates the select side that feeds `unique case(1'b1)` / `unique casez` muxes elsewhere in the codebase. The grant is guaranteed never to have more than one bit set, so downstream unique-case selectors never raise a runtime uniqueness warning.
- Supports grant hold (lock until the requester drops its request) and optional forced preemption after a hold limit.

Parameters:
- N, 3, number of requesters (N >= 2).
- MAX_HOLD, 8, max consecutive grant cycles while another requester waits; 0 = unlimited hold.
- IW, $clog2(N), width of gnt_idx (derived; do not override).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  request vector; bit i high = requester i wants the resource.
- gnt  output  N  registered one-hot grant; all zero when no owner.
- gnt_idx  output  IW  binary index of the current owner; 0 when gnt_vld=0.
- gnt_vld  output  1  high iff gnt != 0.
- preempt  output  1  one-cycle pulse on the cycle the owner is forcibly released.

Behaviour:
- Reset (async assert, sync deassert by clk):
  - gnt=0, gnt_idx=0, gnt_vld=0, preempt=0.
  - ptr=0, hold_cnt=0, state=IDLE.
- FSM states: IDLE, GRANT.
- IDLE:
  - gnt=0.
  - If req != 0, select the first set bit searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (wrap-around).
  - Next cycle: state=GRANT, gnt=onehot(winner), gnt_idx=winner, gnt_vld=1, hold_cnt=0.
  - Latency: 1 cycle from req sampled to gnt.
- GRANT, normal release:
  - Grant held while req[owner]=1.
  - When req[owner]=0 is sampled: next cycle gnt=0 (IDLE), ptr=(owner+1) mod N.
- GRANT, preemption (MAX_HOLD != 0):
  - hold_cnt increments each GRANT cycle, saturating at MAX_HOLD-1.
  - If hold_cnt == MAX_HOLD-1 and (req & ~gnt) != 0: next cycle gnt=0, preempt=1 for that one cycle, ptr=(owner+1) mod N.
  - With no other request pending, the owner keeps its grant indefinitely.
- Mandatory one-cycle bubble (gnt=0) between any two grants, including re-grant to the same requester.
- Simultaneous events:
  - Owner drop and preempt condition in the same cycle: treat as a normal release, preempt=0.
  - New req bits arriving during GRANT are ignored until the next IDLE.
- Reset mid-GRANT: gnt drops to 0 immediately (async). After release, arbitration restarts from ptr=0.
- Invariant on every cycle: gnt is 0 or one-hot, and gnt_vld == |gnt.
- Widths: ptr and gnt_idx are IW bits. Wrap arithmetic is mod N, not mod 2^IW (matters for non-power-of-2 N).

Optional Feature:
- Macro: RR_ARB_FIXED_PRIO_EN.
- Defined: ptr is ignored. Priority is fixed with bit N-1 highest, down to bit 0 lowest (same order as `casez 3'b1??`, `3'b?1?`, `3'b??1`). Hold, preemption and bubble rules are unchanged.
- Undefined: round-robin as described above.

Test Plan (N=3, MAX_HOLD=4 unless noted):
- Reset: rst_n=0 with req=3'b111 → gnt=000, gnt_idx=0, gnt_vld=0, preempt=0. After release, first grant appears 1 cycle later as gnt=001.
- Single request: req=001 for 5 cycles then 000 → gnt=001 for 5 cycles starting 1 cycle after req, then gnt=000; ptr=1.
- Rotation: req=111, each owner drops its bit 2 cycles after being granted and then reasserts it → grant sequence 001, 010, 100, 001, with a 000 bubble between each.
- Preempt: req[0] held high permanently, req[1] asserted on the cycle gnt=001 appears → gnt=001 for exactly 4 cycles, then gnt=000 with preempt=1 for 1 cycle, then gnt=010, gnt_idx=1.
- Wrap: after a grant to 1 (ptr=2), req=101 → gnt=100. After release, with req=101 still set → gnt=001.
- Reset mid-grant: gnt=010 then rst_n pulsed low for 1 cycle → gnt=000 immediately. With req=110 after release → gnt=010 (search starts at ptr=0).
- RR_ARB_FIXED_PRIO_EN defined: req=011, then 110, then 111, each presented from IDLE → gnt=010, 100, 100.
